// File: rtl/cpu_regs_pkg.sv
// Register-file id map and widths shared by the CPU register blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_regs_pkg;

    localparam int REG_ZERO   = 0;   // hardwired zero, writes are meaningless
    localparam int REG_CMP    = 9;
    localparam int REG_SP     = 10;
    localparam int REG_SF     = 11;
    localparam int REG_PC     = 12;
    localparam int REG_LAST   = 12;  // ids above this are unmapped
    localparam int REG_ID_W   = 4;
    localparam int REG_DATA_W = 8;

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for pending register writes: circular buffer with count.
// Latency: push visible at head one cycle after the accepting edge.
// Backpressure: caller must not push when count == DEPTH nor pop when empty.
//
// Ports: clk/rst_n; push + push_dat enqueue; pop dequeues head_dat;
//        flush clears pointers/count; mem/head/count exported for searching.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output logic [W-1:0]                 head_dat,
    output logic [W-1:0]                 mem [DEPTH],
    output logic [$clog2(DEPTH)-1:0]     head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] tail;

    assign head_dat = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_dat;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Buffered write-back in front of the register block's single write port,
// with combinational read-forwarding of pending writes.
// Latency: accepted write appears on write_id/write_value after the next edge.
// Backpressure: in_ready low when full or during flush; output never stalls.
//
// Ports: in_valid/in_ready/in_id/in_value request handshake; flush drops
//        queued entries; write_id/write_value registered retire (id 0 = idle);
//        fwdN_id -> fwdN_hit/fwdN_value forwarding; count = entries queued.
module writeback_queue
    import cpu_regs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ID_W   = REG_ID_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ID_W-1:0]             in_id,
    input  logic [DATA_W-1:0]           in_value,
    input  logic                        flush,
    output logic [ID_W-1:0]             write_id,
    output logic [DATA_W-1:0]           write_value,
    input  logic [ID_W-1:0]             fwd1_id,
    input  logic [ID_W-1:0]             fwd2_id,
    output logic                        fwd1_hit,
    output logic                        fwd2_hit,
    output logic [DATA_W-1:0]           fwd1_value,
    output logic [DATA_W-1:0]           fwd2_value,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int W     = ID_W + DATA_W;

    logic             accept;
    logic             mapped;
    logic             push;
    logic             pop;
    logic [W-1:0]     head_dat;
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;

    assign in_ready = (count < CNT_W'(DEPTH)) && !flush;
    assign accept   = in_valid && in_ready;
    // Writes to the zero register or unmapped ids are handshaken but dropped.
    assign mapped   = (in_id != ID_W'(REG_ZERO)) && (in_id <= ID_W'(REG_LAST));
    assign push     = accept && mapped;
    assign pop      = (count != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({in_id, in_value}),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .mem      (mem),
        .head     (head),
        .count    (count)
    );

    // Output register retires the head every cycle; flush does not cancel it
    // because the head was already committed to leave this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_id    <= '0;
            write_value <= '0;
        end else if (pop) begin
            write_id    <= head_dat[W-1 -: ID_W];
            write_value <= head_dat[DATA_W-1:0];
        end else begin
            write_id    <= '0;
            write_value <= '0;
        end
    end

    // Newest match wins: output register is oldest, then queue head..tail,
    // so later assignments override earlier ones. Returns {hit, value}.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ID_W-1:0] id);
        logic [DATA_W:0]  r;
        logic [PTR_W-1:0] idx;
        r = '0;
        if (id != '0) begin
            if (write_id == id) begin
                r = {1'b1, write_value};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < count) && (mem[idx][W-1 -: ID_W] == id)) begin
                    r = {1'b1, mem[idx][DATA_W-1:0]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_value} = fwd_lookup(fwd1_id);
        {fwd2_hit, fwd2_value} = fwd_lookup(fwd2_id);
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized + directed bench for writeback_queue with a queue-based model
// and a negedge monitor that pops expected retires from a scoreboard.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int ID_W   = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ID_W-1:0]   in_id = '0;
    logic [DATA_W-1:0] in_value = '0;
    logic              flush = 1'b0;
    logic [ID_W-1:0]   write_id;
    logic [DATA_W-1:0] write_value;
    logic [ID_W-1:0]   fwd1_id = '0;
    logic [ID_W-1:0]   fwd2_id = '0;
    logic              fwd1_hit, fwd2_hit;
    logic [DATA_W-1:0] fwd1_value, fwd2_value;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_value(in_value),
        .flush(flush), .write_id(write_id), .write_value(write_value),
        .fwd1_id(fwd1_id), .fwd2_id(fwd2_id),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_value(fwd1_value), .fwd2_value(fwd2_value),
        .count(count)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] val;
    } wr_t;

    wr_t m_q[$];     // pending writes, oldest first
    wr_t exp_q[$];   // scoreboard of expected retires
    wr_t mo;         // model of the output register
    wr_t mon_e;
    wr_t new_w;
    bit  acc_ok;
    bit  mon_en = 1'b0;
    logic              eh;
    logic [DATA_W-1:0] ev;
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_mapped(input logic [ID_W-1:0] id);
        return (int'(id) >= 1) && (int'(id) <= 12);
    endfunction

    function automatic void exp_fwd(input logic [ID_W-1:0] id, output logic hit,
                                    output logic [DATA_W-1:0] val);
        hit = 1'b0;
        val = '0;
        if (id == '0) return;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].id == id) begin
                hit = 1'b1;
                val = m_q[i].val;
                return;
            end
        end
        if (mo.id == id) begin
            hit = 1'b1;
            val = mo.val;
        end
    endfunction

    // Reference model: retire from pre-edge queue, then accept or flush.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            mo.id  = '0;
            mo.val = '0;
        end else begin
            acc_ok = in_valid && !flush && (m_q.size() < DEPTH);
            if (m_q.size() > 0) begin
                mo = m_q.pop_front();
                exp_q.push_back(mo);
            end else begin
                mo.id  = '0;
                mo.val = '0;
            end
            if (flush) begin
                m_q.delete();
            end else if (acc_ok && is_mapped(in_id)) begin
                new_w.id  = in_id;
                new_w.val = in_value;
                m_q.push_back(new_w);
            end
        end
    end

    // Monitor: a non-zero write_id or an outstanding expectation is compared.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
            end else begin
                mon_e.id  = '0;
                mon_e.val = '0;
            end
            chk("write_id", 32'(write_id), 32'(mon_e.id));
            chk("write_value", 32'(write_value), 32'(mon_e.val));
            chk("count", 32'(count), 32'(m_q.size()));
            chk("in_ready", 32'(in_ready), 32'((m_q.size() < DEPTH) && !flush));
            exp_fwd(fwd1_id, eh, ev);
            chk("fwd1_hit", 32'(fwd1_hit), 32'(eh));
            chk("fwd1_value", 32'(fwd1_value), 32'(ev));
            exp_fwd(fwd2_id, eh, ev);
            chk("fwd2_hit", 32'(fwd2_hit), 32'(eh));
            chk("fwd2_value", 32'(fwd2_value), 32'(ev));
        end
    end

    task automatic drive(input bit v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] val,
                         input bit fl, input logic [ID_W-1:0] f1, input logic [ID_W-1:0] f2);
        in_valid = v;
        in_id    = id;
        in_value = val;
        flush    = fl;
        fwd1_id  = f1;
        fwd2_id  = f2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [ID_W-1:0] f1, input logic [ID_W-1:0] f2);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, f1, f2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_write_id", 32'(write_id), 32'd0);
        chk("reset_write_value", 32'(write_value), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // single write, one-cycle presentation
        drive(1'b1, 4'd3, 8'h5A, 1'b0, 4'd3, 4'd0);
        idle(4, 4'd3, 4'd0);

        // back-to-back pushes
        for (int i = 1; i <= 5; i++) drive(1'b1, ID_W'(i), DATA_W'(8'h10 + i), 1'b0, ID_W'(i), 4'd1);
        idle(3, 4'd0, 4'd0);

        // filtered ids
        drive(1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 4'd14);
        drive(1'b1, 4'd14, 8'h11, 1'b0, 4'd14, 4'd0);
        idle(3, 4'd0, 4'd14);

        // same-id forwarding priority
        drive(1'b1, 4'd9, 8'h01, 1'b0, 4'd9, 4'd9);
        drive(1'b1, 4'd9, 8'h02, 1'b0, 4'd9, 4'd9);
        idle(4, 4'd9, 4'd9);

        // flush with input offered
        drive(1'b1, 4'd1, 8'hA1, 1'b0, 4'd1, 4'd3);
        drive(1'b1, 4'd2, 8'hA2, 1'b0, 4'd2, 4'd3);
        drive(1'b1, 4'd3, 8'hA3, 1'b0, 4'd3, 4'd2);
        drive(1'b1, 4'd4, 8'hA4, 1'b1, 4'd4, 4'd3);
        idle(3, 4'd4, 4'd3);

        // reset mid-drain
        drive(1'b1, 4'd5, 8'hB5, 1'b0, 4'd7, 4'd6);
        drive(1'b1, 4'd6, 8'hB6, 1'b0, 4'd7, 4'd6);
        drive(1'b1, 4'd7, 8'hB7, 1'b0, 4'd7, 4'd6);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_write_id", 32'(write_id), 32'd0);
        chk("rst_mid_write_value", 32'(write_value), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("rst_mid_fwd2_hit", 32'(fwd2_hit), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4, 4'd7, 4'd6);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  ID_W'($urandom_range(0, 15)),
                  DATA_W'($urandom),
                  ($urandom_range(0, 19) == 0),
                  ID_W'($urandom_range(0, 5)),
                  ID_W'($urandom_range(0, 15)));
        end
        idle(4, 4'd0, 4'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
